// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction BRAM between fetch (reads) and the program loader (writes).
// Optional grant/conflict statistics are enabled by defining IMEM_ARB_STATS_EN.
`ifndef LEN_INST
`define LEN_INST 32
`endif

module imem_arbiter #(
    parameter int unsigned LEN_MEMISTR_ADDR = 15,
    parameter int unsigned MAX_WAIT         = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        f_order,
    output logic                        f_accepted,
    output logic                        f_done,
    input  logic [LEN_MEMISTR_ADDR-1:0] f_addr,
    output logic [`LEN_INST-1:0]        f_inst,
    input  logic                        l_order,
    output logic                        l_accepted,
    output logic                        l_done,
    input  logic [LEN_MEMISTR_ADDR-1:0] l_addr,
    input  logic [`LEN_INST-1:0]        l_data,
    output logic [LEN_MEMISTR_ADDR-1:0] a_inst_mem,
    output logic [`LEN_INST-1:0]        w_inst_mem,
    output logic                        we_inst_mem,
`ifdef IMEM_ARB_STATS_EN
    input  logic                        stat_clr,
    output logic [31:0]                 stat_fetch_grants,
    output logic [31:0]                 stat_load_grants,
    output logic [31:0]                 stat_conflicts,
`endif
    input  logic [`LEN_INST-1:0]        d_inst_mem
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned ADDR_W = LEN_MEMISTR_ADDR;

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        f_pipe_q, f_pipe_d;
    logic              l_done_q, l_done_d;
    logic              fetch_forced;
    logic              f_grant;
    logic              l_grant;

    // Grant, starvation counter and BRAM pin muxing.
    always_comb begin
        fetch_forced = (wait_q == WAIT_W'(MAX_WAIT));
        f_grant      = f_order & (~l_order | fetch_forced);
        l_grant      = l_order & ~f_grant;

        wait_d = wait_q;
        if (!f_order || f_grant) begin
            wait_d = '0;
        end else if (!fetch_forced) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        addr_d = addr_q;
        if (f_grant) begin
            addr_d = f_addr;
        end else if (l_grant) begin
            addr_d = l_addr;
        end

        f_pipe_d = {f_pipe_q[0], f_grant};
        l_done_d = l_grant;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_q   <= '0;
            addr_q   <= '0;
            f_pipe_q <= '0;
            l_done_q <= 1'b0;
        end else begin
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            f_pipe_q <= f_pipe_d;
            l_done_q <= l_done_d;
        end
    end

    // BRAM address must be valid in the grant cycle, so the pins are driven combinationally.
    assign f_accepted  = f_grant;
    assign l_accepted  = l_grant;
    assign a_inst_mem  = addr_d;
    assign w_inst_mem  = l_data;
    assign we_inst_mem = l_grant;
    assign f_inst      = d_inst_mem;
    assign f_done      = f_pipe_q[1];
    assign l_done      = l_done_q;

`ifdef IMEM_ARB_STATS_EN
    logic [31:0] fetch_cnt_q, load_cnt_q, conf_cnt_q;

    // Saturating event counters; stat_clr wins over increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_cnt_q <= '0;
            load_cnt_q  <= '0;
            conf_cnt_q  <= '0;
        end else if (stat_clr) begin
            fetch_cnt_q <= '0;
            load_cnt_q  <= '0;
            conf_cnt_q  <= '0;
        end else begin
            if (f_grant && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (l_grant && (load_cnt_q != 32'hFFFF_FFFF))  load_cnt_q  <= load_cnt_q + 32'd1;
            if (f_order && l_order && (conf_cnt_q != 32'hFFFF_FFFF)) conf_cnt_q <= conf_cnt_q + 32'd1;
        end
    end

    assign stat_fetch_grants = fetch_cnt_q;
    assign stat_load_grants  = load_cnt_q;
    assign stat_conflicts    = conf_cnt_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard testbench for imem_arbiter with a 2-cycle registered-read BRAM model.
`ifndef LEN_INST
`define LEN_INST 32
`endif

module tb_imem_arbiter;

    localparam int unsigned AW = 15;
    localparam int unsigned IW = `LEN_INST;
    localparam int unsigned MW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          f_order, f_accepted, f_done;
    logic [AW-1:0] f_addr;
    logic [IW-1:0] f_inst;
    logic          l_order, l_accepted, l_done;
    logic [AW-1:0] l_addr;
    logic [IW-1:0] l_data;
    logic [AW-1:0] a_inst_mem;
    logic [IW-1:0] w_inst_mem;
    logic          we_inst_mem;
    logic [IW-1:0] d_inst_mem;
`ifdef IMEM_ARB_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_fetch_grants, stat_load_grants, stat_conflicts;
`endif

    imem_arbiter #(.LEN_MEMISTR_ADDR(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rstn(rstn),
        .f_order(f_order), .f_accepted(f_accepted), .f_done(f_done),
        .f_addr(f_addr), .f_inst(f_inst),
        .l_order(l_order), .l_accepted(l_accepted), .l_done(l_done),
        .l_addr(l_addr), .l_data(l_data),
        .a_inst_mem(a_inst_mem), .w_inst_mem(w_inst_mem), .we_inst_mem(we_inst_mem),
`ifdef IMEM_ARB_STATS_EN
        .stat_clr(stat_clr), .stat_fetch_grants(stat_fetch_grants),
        .stat_load_grants(stat_load_grants), .stat_conflicts(stat_conflicts),
`endif
        .d_inst_mem(d_inst_mem)
    );

    always #5 clk = ~clk;

    // BRAM: read-before-write, two register stages on the read path.
    logic [IW-1:0] mem [0:(1<<AW)-1];
    logic [IW-1:0] rd1;
    always @(posedge clk) begin
        if (we_inst_mem) mem[a_inst_mem] <= w_inst_mem;
        rd1        <= mem[a_inst_mem];
        d_inst_mem <= rd1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int            due;
        logic [IW-1:0] data;
    } fexp_t;

    fexp_t         fq[$];
    int            lq[$];
    logic [IW-1:0] shadow [int];

    // Monitor: pops done pulses against the scoreboard, pushes new expectations on grants.
    always @(negedge clk) begin
        fexp_t e;
        if (fq.size() > 0 && fq[0].due == cyc) begin
            e = fq.pop_front();
            check("f_done", 32'(f_done), 32'd1);
            check("f_inst", 32'(f_inst), 32'(e.data));
        end else if (f_done) begin
            check("f_done_spurious", 32'(f_done), 32'd0);
        end
        if (lq.size() > 0 && lq[0] == cyc) begin
            void'(lq.pop_front());
            check("l_done", 32'(l_done), 32'd1);
        end else if (l_done) begin
            check("l_done_spurious", 32'(l_done), 32'd0);
        end
        if (f_accepted) begin
            check("grant_onehot", 32'(l_accepted), 32'd0);
            check("f_bram_addr", 32'(a_inst_mem), 32'(f_addr));
            check("f_bram_we", 32'(we_inst_mem), 32'd0);
            e.due  = cyc + 2;
            e.data = shadow.exists(int'(f_addr)) ? shadow[int'(f_addr)] : '0;
            fq.push_back(e);
        end
        if (l_accepted) begin
            check("l_bram_addr", 32'(a_inst_mem), 32'(l_addr));
            check("l_bram_data", 32'(w_inst_mem), 32'(l_data));
            check("l_bram_we", 32'(we_inst_mem), 32'd1);
            lq.push_back(cyc + 1);
            shadow[int'(l_addr)] = l_data;
        end
        if (!f_accepted && !l_accepted) check("idle_we", 32'(we_inst_mem), 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input bit is_f, input string tag);
        int n = 0;
        @(negedge clk);
        while (!(is_f ? f_accepted : l_accepted) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(is_f ? f_accepted : l_accepted), 32'd1);
        step();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [IW-1:0] d);
        l_addr = a; l_data = d; l_order = 1'b1;
        wait_acc(1'b0, "l_accept");
        l_order = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        f_addr = a; f_order = 1'b1;
        wait_acc(1'b1, "f_accept");
        f_order = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((fq.size() != 0 || lq.size() != 0) && n < 20) begin
            step();
            n++;
        end
        check("drain", 32'(fq.size() + lq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int run, max_run, got, exp;
        rstn = 1'b0; f_order = 1'b0; l_order = 1'b0;
        f_addr = '0; l_addr = '0; l_data = '0;
`ifdef IMEM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        step(); step();
        check("rst_f_accepted", 32'(f_accepted), 32'd0);
        check("rst_l_accepted", 32'(l_accepted), 32'd0);
        check("rst_f_done", 32'(f_done), 32'd0);
        check("rst_l_done", 32'(l_done), 32'd0);
        check("rst_we", 32'(we_inst_mem), 32'd0);
        rstn = 1'b1;
        step();

        // Preload 0..3 through the loader, then stream reads back-to-back.
        for (int i = 0; i < 4; i++) do_write(AW'(i), IW'(32'h1000 + i));
        drain();
        f_order = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_addr = AW'(i);
            @(negedge clk);
            check("f_b2b_accept", 32'(f_accepted), 32'd1);
            step();
        end
        f_order = 1'b0;
        drain();

        // Write then read the next cycle sees new data.
        do_write(AW'(5), IW'(32'hDEAD_BEEF));
        do_read(AW'(5));
        drain();

        // Sustained conflict: loader MW times, then forced fetch.
        f_addr = AW'(100); l_addr = AW'(100); l_data = IW'(32'hA5A5_0001);
        f_order = 1'b1; l_order = 1'b1;
        run = 0; max_run = 0;
        for (int i = 0; i < 2 * (MW + 1); i++) begin
            @(negedge clk);
            got = f_accepted ? 2 : (l_accepted ? 1 : 0);
            exp = ((i % (MW + 1)) == MW) ? 2 : 1;
            check("conflict_grant", 32'(got), 32'(exp));
            run = f_accepted ? 0 : run + 1;
            if (run > max_run) max_run = run;
            step();
        end
        f_order = 1'b0; l_order = 1'b0;
        check("max_fetch_denial", 32'(max_run), 32'(MW));
        drain();

        // Read in flight keeps old data; a later read sees the write.
        do_write(AW'(7), IW'(32'h11));
        drain();
        f_addr = AW'(7); f_order = 1'b1;
        @(negedge clk);
        check("inflight_f_accept", 32'(f_accepted), 32'd1);
        step();
        f_order = 1'b0;
        l_addr = AW'(7); l_data = IW'(32'h22); l_order = 1'b1;
        @(negedge clk);
        check("inflight_l_accept", 32'(l_accepted), 32'd1);
        step();
        l_order = 1'b0;
        do_read(AW'(7));
        drain();

        // Asynchronous reset with a read in flight drops its done.
        f_addr = AW'(2); f_order = 1'b1;
        @(negedge clk);
        check("rst_mid_f_accept", 32'(f_accepted), 32'd1);
        step();
        f_order = 1'b0;
        #2;
        rstn = 1'b0;
        fq.delete();
        lq.delete();
        #1;
        check("rst_mid_f_accepted", 32'(f_accepted), 32'd0);
        check("rst_mid_l_accepted", 32'(l_accepted), 32'd0);
        check("rst_mid_f_done", 32'(f_done), 32'd0);
        check("rst_mid_l_done", 32'(l_done), 32'd0);
        check("rst_mid_we", 32'(we_inst_mem), 32'd0);
        step(); step(); step();
        rstn = 1'b1;
        step(); step();
        do_read(AW'(3));
        drain();

`ifdef IMEM_ARB_STATS_EN
        // Counters: 3 conflict cycles then 2 fetch-only cycles.
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        f_addr = AW'(200); l_addr = AW'(201); l_data = IW'(32'h5555);
        f_order = 1'b1; l_order = 1'b1;
        step(); step(); step();
        l_order = 1'b0;
        step(); step();
        f_order = 1'b0;
        step();
        check("stat_conflicts", stat_conflicts, 32'd3);
        check("stat_fetch_grants", stat_fetch_grants, 32'd2);
        check("stat_load_grants", stat_load_grants, 32'd3);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check("stat_clr_conflicts", stat_conflicts, 32'd0);
        check("stat_clr_fetch", stat_fetch_grants, 32'd0);
        check("stat_clr_load", stat_load_grants, 32'd0);
        drain();
`endif

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port instruction BRAM between two requesters: the fetch unit (read port) and the program loader (write port, fed from the UART boot path).
- Sits between fetch/loader and the BRAM and owns the BRAM address, data and write-enable pins.
- Uses the order/accepted/done handshake on both sides, so fetch can stay a fixed 2-stage pipeline while the loader streams instructions in.

Parameters:
- LEN_MEMISTR_ADDR, 15, BRAM word-address width.
- MAX_WAIT, 4, consecutive cycles fetch may be denied before it gets forced priority (range 1..15).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- f_order  in  1  fetch read request.
- f_accepted  out  1  fetch request granted this cycle.
- f_done  out  1  f_inst valid.
- f_addr  in  LEN_MEMISTR_ADDR  fetch word address.
- f_inst  out  `LEN_INST  read data.
- l_order  in  1  loader write request.
- l_accepted  out  1  loader request granted this cycle.
- l_done  out  1  write committed.
- l_addr  in  LEN_MEMISTR_ADDR  loader word address.
- l_data  in  `LEN_INST  write data.
- a_inst_mem  out  LEN_MEMISTR_ADDR  BRAM address.
- w_inst_mem  out  `LEN_INST  BRAM write data.
- we_inst_mem  out  1  BRAM write enable.
- d_inst_mem  in  `LEN_INST  BRAM read data (2-cycle registered read).

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-low (rstn). All state clears on rstn=0, including mid-operation; in-flight reads and writes are dropped with no done.
- Reset values: f_accepted=0, l_accepted=0, f_done=0, l_done=0, we_inst_mem=0, wait counter=0.
- Grant is combinational from the orders and registered state. At most one grant per cycle.
- Default priority: loader.
- Starvation counter:
  - Counts cycles with f_order=1 and f_accepted=0.
  - Cleared on f_accepted, or when f_order=0.
  - Saturates at MAX_WAIT.
  - When it equals MAX_WAIT, fetch wins the next conflict; the counter then clears.
- Fetch grant:
  - a_inst_mem=f_addr, we_inst_mem=0.
  - 2-stage valid pipe; f_done=1 exactly 2 cycles after f_accepted.
  - f_inst = d_inst_mem, passed straight through; valid only while f_done=1.
  - Back-to-back reads accepted every cycle, giving full throughput.
- Loader grant:
  - a_inst_mem=l_addr, w_inst_mem=l_data, we_inst_mem=1.
  - l_done=1 exactly 1 cycle after l_accepted.
- Idle: a_inst_mem holds its last value, we_inst_mem=0, w_inst_mem don't-care.
- Ordering:
  - A write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
  - Reads already in flight return the old data.
  - The arbiter adds no forwarding.
- Done pulses from earlier grants are never suppressed by new grants. f_done and l_done can both be 1 in the same cycle.
- Orders are level requests. A requester keeps its order, address and data stable until accepted. The arbiter has no internal queue.

Optional Feature:
- Macro: IMEM_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_fetch_grants[31:0], stat_load_grants[31:0] and stat_conflicts[31:0].
  - stat_conflicts counts cycles with f_order and l_order both 1.
  - All three counters saturate at 32'hFFFFFFFF and reset to 0.
  - Adds input stat_clr, a synchronous clear that takes priority over increment.
- When undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Fetch only: f_order=1 at addr 0..3 for 4 consecutive cycles, BRAM preloaded with 0x1000+i -> f_accepted=1 every cycle; f_done rises 2 cycles after the first grant; f_inst sequence is 0x1000..0x1003.
- Write then read: loader writes 0xDEADBEEF to addr 5 (l_done one cycle later); fetch reads addr 5 the next cycle -> f_inst=0xDEADBEEF 2 cycles after its grant.
- Conflict, MAX_WAIT=4: both orders held high continuously -> loader granted 4 cycles, fetch granted cycle 5, then loader again; pattern repeats; fetch is never denied 5 cycles in a row.
- Read in flight, then write: fetch reads addr 7 (old value 0x11) in cycle N; loader writes 0x22 to addr 7 in cycle N+1 -> f_inst=0x11 at N+2; a new read of addr 7 returns 0x22.
- Reset mid-operation: fetch accepted in cycle N; rstn=0 asynchronously in cycle N+1 -> f_done stays 0; all outputs at reset values; after release, the first grant works normally.
- With IMEM_ARB_STATS_EN: 3 conflict cycles plus 2 fetch-only cycles -> stat_conflicts=3; stat_fetch_grants and stat_load_grants match the grant log; stat_clr=1 for one cycle -> all counters 0.
